time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_pkg.sv | 17 +
 rtl/time_set_ctrl_if.sv | 20 ++
 rtl/time_set_ctrl_field_adj.sv | 14 +
 rtl/time_set_ctrl.sv | 98 +++++++++
 tb/tb_time_set_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: shared field limits, state encoding and field-select decode for the time-set controller
package time_set_ctrl_pkg;
  localparam int TW = 6;
  localparam logic [TW-1:0] HOUR_MAX = 6'd23;
  localparam logic [TW-1:0] MINUTE_MAX = 6'd59;
  localparam logic [TW-1:0] SECOND_MAX = 6'd59;
  typedef enum logic [2:0] {
    RUN = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    COMMIT = 3'd4
  } state_t;
  function automatic logic [1:0] sel_of(state_t s);
    return (s == SET_HOUR) ? 2'd1 : (s == SET_MIN) ? 2'd2 : (s == SET_SEC) ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: keys and live time in, counter control, commit values and display out
interface time_set_ctrl_if;
  import time_set_ctrl_pkg::*;
  logic key_mode, key_inc, key_dec;
  logic [TW-1:0] cur_hour, cur_minute, cur_second;
  logic run_en, load, blink_on;
  logic [TW-1:0] load_hour, load_minute, load_second;
  logic [TW-1:0] disp_hour, disp_minute, disp_second;
  logic [1:0] field_sel;
  modport master (
    output key_mode, key_inc, key_dec, cur_hour, cur_minute, cur_second,
    input run_en, load, blink_on, load_hour, load_minute, load_second,
    input disp_hour, disp_minute, disp_second, field_sel
  );
  modport slave (
    input key_mode, key_inc, key_dec, cur_hour, cur_minute, cur_second,
    output run_en, load, blink_on, load_hour, load_minute, load_second,
    output disp_hour, disp_minute, disp_second, field_sel
  );
endinterface

// File: rtl/time_set_ctrl_field_adj.sv
// field_adj: wrapping increment/decrement of one time field; both keys together leave it unchanged
module field_adj
  import time_set_ctrl_pkg::*;
(
  input  logic [TW-1:0] i_value,
  input  logic [TW-1:0] i_max,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [TW-1:0] o_next
);
  always_comb
    o_next = (i_inc & ~i_dec) ? ((i_value == i_max) ? '0 : i_value + 1'b1) :
             (i_dec & ~i_inc) ? ((i_value == '0) ? i_max : i_value - 1'b1) : i_value;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: clock time-set FSM with field editing, blink of the selected field and idle timeout
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int BLINK_HALF = 24_999_999,
  parameter int TIMEOUT_HALVES = 20
) (
  input logic clk,
  input logic rst,
  time_set_ctrl_if.slave bus
);
  localparam int CW = $clog2(BLINK_HALF + 1);
  localparam int IW = $clog2(TIMEOUT_HALVES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BLINK_HALF);
  localparam logic [IW-1:0] I_LAST = IW'(TIMEOUT_HALVES - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idle;
  logic r_blink, r_run_en, r_load;
  logic [1:0] r_sel;
  logic [TW-1:0] r_eh, r_em, r_es, r_lh, r_lm, r_ls, w_h, w_m, w_s;
  logic w_set, w_key, w_tick, w_timeout;
  always_comb begin
    w_set = r_state inside {SET_HOUR, SET_MIN, SET_SEC};
    w_key = bus.key_mode | bus.key_inc | bus.key_dec;
    w_tick = w_set & ~w_key & (r_cnt == C_LAST);
    w_timeout = w_tick & (r_idle == I_LAST);
    w_next = r_state;
    case (r_state)
      RUN:      w_next = bus.key_mode ? SET_HOUR : RUN;
      SET_HOUR: w_next = bus.key_mode ? SET_MIN : w_timeout ? RUN : SET_HOUR;
      SET_MIN:  w_next = bus.key_mode ? SET_SEC : w_timeout ? RUN : SET_MIN;
      SET_SEC:  w_next = bus.key_mode ? COMMIT : w_timeout ? RUN : SET_SEC;
      default:  w_next = RUN;
    endcase
  end
  // a key_mode press wins over inc/dec, so adjusts are gated off in that cycle
  field_adj u_hour (
    .i_value(r_eh), .i_max(HOUR_MAX),
    .i_inc(bus.key_inc & ~bus.key_mode & (r_state == SET_HOUR)),
    .i_dec(bus.key_dec & ~bus.key_mode & (r_state == SET_HOUR)),
    .o_next(w_h)
  );
  field_adj u_minute (
    .i_value(r_em), .i_max(MINUTE_MAX),
    .i_inc(bus.key_inc & ~bus.key_mode & (r_state == SET_MIN)),
    .i_dec(bus.key_dec & ~bus.key_mode & (r_state == SET_MIN)),
    .o_next(w_m)
  );
  field_adj u_second (
    .i_value(r_es), .i_max(SECOND_MAX),
    .i_inc(bus.key_inc & ~bus.key_mode & (r_state == SET_SEC)),
    .i_dec(bus.key_dec & ~bus.key_mode & (r_state == SET_SEC)),
    .o_next(w_s)
  );
  always_ff @(posedge clk)
    if (!rst) r_state <= RUN;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (!rst) {r_eh, r_em, r_es} <= '0;
    else if (r_state == RUN && bus.key_mode) {r_eh, r_em, r_es} <= {bus.cur_hour, bus.cur_minute, bus.cur_second};
    else {r_eh, r_em, r_es} <= {w_h, w_m, w_s};
  // outputs are registered from the next state so they line up with r_state
  always_ff @(posedge clk)
    if (!rst) begin
      r_run_en <= 1'b1;
      r_load <= 1'b0;
      r_sel <= 2'd0;
      {r_lh, r_lm, r_ls} <= '0;
    end else begin
      r_run_en <= w_next == RUN;
      r_load <= w_next == COMMIT;
      r_sel <= sel_of(w_next);
      if (w_next == COMMIT) {r_lh, r_lm, r_ls} <= {r_eh, r_em, r_es};
    end
  always_ff @(posedge clk)
    if (!rst || !w_set || w_key || w_timeout) begin
      r_cnt <= '0;
      r_idle <= '0;
      r_blink <= 1'b1;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idle <= r_idle + 1'b1;
      r_blink <= ~r_blink;
    end else r_cnt <= r_cnt + 1'b1;
  always_comb begin
    bus.run_en = r_run_en;
    bus.load = r_load;
    bus.field_sel = r_sel;
    bus.blink_on = r_blink;
    bus.load_hour = r_lh;
    bus.load_minute = r_lm;
    bus.load_second = r_ls;
    bus.disp_hour = (r_state == RUN) ? bus.cur_hour : r_eh;
    bus.disp_minute = (r_state == RUN) ? bus.cur_minute : r_em;
    bus.disp_second = (r_state == RUN) ? bus.cur_second : r_es;
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and random key stimulus against a cycle-count reference model with a decoupled scoreboard
module tb_time_set_ctrl;
  localparam int BH = 3;
  localparam int TH = 4;
  localparam int HALF = BH + 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  time_set_ctrl_if bus ();
  time_set_ctrl #(.BLINK_HALF(BH), .TIMEOUT_HALVES(TH)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic run_en;
    logic load;
    logic [1:0] sel;
    logic blink;
    logic [5:0] lh, lm, ls, dh, dm, ds;
  } obs_t;
  obs_t exp_q[$];
  logic [17:0] load_q[$];
  int checks = 0, errors = 0, cyc_n = 0;
  int mode = 0, idle = 0;
  int e[3], l[3], cur[3];
  function automatic int max_of(int f);
    return (f == 0) ? 23 : 59;
  endfunction
  // mode: 0 run, 1..3 editing field mode-1, 4 commit; idle counts key-free cycles since entry/last key
  task automatic step(input logic r, input logic km, input logic ki, input logic kd);
    obs_t x;
    @(negedge clk);
    rst = r;
    bus.key_mode = km;
    bus.key_inc = ki;
    bus.key_dec = kd;
    bus.cur_hour = 6'(cur[0]);
    bus.cur_minute = 6'(cur[1]);
    bus.cur_second = 6'(cur[2]);
    if (!r) begin
      mode = 0;
      idle = 0;
      e = '{0, 0, 0};
      l = '{0, 0, 0};
    end else if (mode == 0) begin
      if (km) begin
        e = cur;
        mode = 1;
        idle = 0;
      end
    end else if (mode == 4) mode = 0;
    else if (km) begin
      mode++;
      idle = 0;
      if (mode == 4) begin
        l = e;
        load_q.push_back({6'(e[0]), 6'(e[1]), 6'(e[2])});
      end
    end else if (ki || kd) begin
      int f, m;
      idle = 0;
      f = mode - 1;
      m = max_of(f) + 1;
      if (ki != kd) e[f] = ki ? (e[f] + 1) % m : (e[f] + m - 1) % m;
    end else begin
      idle++;
      if (idle == HALF * TH) begin
        mode = 0;
        idle = 0;
      end
    end
    x.run_en = mode == 0;
    x.load = mode == 4;
    x.sel = (mode >= 1 && mode <= 3) ? 2'(mode) : 2'd0;
    x.blink = (mode >= 1 && mode <= 3) ? ((idle / HALF) % 2 == 0) : 1'b1;
    x.lh = 6'(l[0]);
    x.lm = 6'(l[1]);
    x.ls = 6'(l[2]);
    x.dh = 6'(mode == 0 ? cur[0] : e[0]);
    x.dm = 6'(mode == 0 ? cur[1] : e[1]);
    x.ds = 6'(mode == 0 ? cur[2] : e[2]);
    exp_q.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      obs_t a, x;
      logic [17:0] lv, la;
      x = exp_q.pop_front();
      a = {bus.run_en, bus.load, bus.field_sel, bus.blink_on, bus.load_hour, bus.load_minute,
           bus.load_second, bus.disp_hour, bus.disp_minute, bus.disp_second};
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL outputs cycle %0d got %h expected %h", cyc_n, a, x);
      end
      if (bus.load === 1'b1) begin
        la = {bus.load_hour, bus.load_minute, bus.load_second};
        checks++;
        if (load_q.size() == 0) begin
          errors++;
          $display("FAIL load_pulse cycle %0d got load=1 values %h expected no pulse", cyc_n, la);
        end else begin
          lv = load_q.pop_front();
          if (la !== lv) begin
            errors++;
            $display("FAIL load_values cycle %0d got %h expected %h", cyc_n, la, lv);
          end
        end
      end
      cyc_n++;
    end
  end
  initial begin
    bus.key_mode = 1'b0;
    bus.key_inc = 1'b0;
    bus.key_dec = 1'b0;
    cur = '{12, 34, 56};
    bus.cur_hour = 6'd12;
    bus.cur_minute = 6'd34;
    bus.cur_second = 6'd56;
    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (11) step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    repeat (8) step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    repeat (34) step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    repeat (8) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    repeat (2) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    repeat (47) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    repeat (20) step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int q;
      q = ((i / 30) % 3 == 0) ? 1 : 0;
      cur = '{$urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59)};
      if (q == 1)
        step($urandom_range(0, 199) != 0, $urandom_range(0, 49) == 0, 1'b0, 1'b0);
      else
        step($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (load_q.size() != 0) begin
      errors++;
      $display("FAIL load_pending got %0d queued expected 0", load_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_pending got %0d queued expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
